// File: rtl/iob_fifo_sync_asym_rgtw.sv
// Synchronous FIFO with a narrow write port and a wide read port. Storage lives
// in R external 2-port RAM blocks; this block owns the pointers, level and enables.
module iob_fifo_sync_asym_rgtw #(
  parameter int W_DATA_W = 8,
  parameter int R_DATA_W = 32,
  parameter int ADDR_W   = 4,
  localparam int R         = R_DATA_W / W_DATA_W,
  localparam int RL        = $clog2(R),
  localparam int MINADDR_W = ADDR_W - RL
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      w_en_i,
  input  logic [W_DATA_W-1:0]       w_data_i,
  output logic                      w_full_o,
  input  logic                      r_en_i,
  output logic [R_DATA_W-1:0]       r_data_o,
  output logic                      r_empty_o,
  output logic [ADDR_W:0]           level_o,
  output logic [R-1:0]              ext_mem_w_en_o,
  output logic [MINADDR_W*R-1:0]    ext_mem_w_addr_o,
  output logic [W_DATA_W*R-1:0]     ext_mem_w_data_o,
  output logic                      ext_mem_r_en_o,
  output logic [MINADDR_W*R-1:0]    ext_mem_r_addr_o,
  input  logic [W_DATA_W*R-1:0]     ext_mem_r_data_i
);

  localparam logic [ADDR_W:0] CAPACITY = (ADDR_W + 1)'(1) << ADDR_W;
  localparam logic [ADDR_W:0] WIDE     = (ADDR_W + 1)'(R);

  logic [ADDR_W-1:0]    wptr;
  logic [MINADDR_W-1:0] rptr;
  logic [ADDR_W:0]      level;
  logic                 wa;
  logic                 ra;

  assign w_full_o  = (level == CAPACITY);
  assign r_empty_o = (level < WIDE);
  assign level_o   = level;

  assign wa = w_en_i & ~w_full_o & ~rst_i;
  assign ra = r_en_i & ~r_empty_o & ~rst_i;

  assign ext_mem_r_en_o = ra;
  // Blocks are packed little-endian: block p feeds lane p of the wide word.
  assign r_data_o = ext_mem_r_data_i;

  always_comb begin
    ext_mem_w_en_o   = '0;
    ext_mem_w_addr_o = '0;
    ext_mem_w_data_o = '0;
    ext_mem_r_addr_o = '0;
    for (int unsigned p = 0; p < R; p++) begin
      ext_mem_w_en_o[p] = wa && (wptr[RL-1:0] == RL'(p));
      ext_mem_w_addr_o[p*MINADDR_W +: MINADDR_W] = wptr[ADDR_W-1:RL];
      ext_mem_w_data_o[p*W_DATA_W +: W_DATA_W]   = w_data_i;
      ext_mem_r_addr_o[p*MINADDR_W +: MINADDR_W] = rptr;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (wa) wptr <= wptr + 1'b1;
      if (ra) rptr <= rptr + 1'b1;
      level <= level + {{ADDR_W{1'b0}}, wa} - (ra ? WIDE : '0);
    end
  end

endmodule
